// File: rtl/logic_unit_mc.sv
// Handshaked AND/OR/XOR/NOR unit that popcounts the result one byte per cycle; response valid WIDTH/8 cycles after accept.
// Takes one request at a time; the response is held stable in DONE for as long as rsp_ready stays low.
module logic_unit_mc #(
   parameter int WIDTH = 32,
   parameter int POPW  = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [POPW-1:0]  rsp_pop,
   output logic             rsp_zero
);

   localparam int NBYTES = WIDTH / 8;
   localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic             ready_q;
   logic [WIDTH-1:0] result;
   logic [POPW-1:0]  acc;
   logic [IDXW-1:0]  idx;

   logic [WIDTH-1:0] op_res;
   logic [7:0]       cur_byte;
   logic [3:0]       byte_pop;

   always_comb begin
      op_res = '0;
      case (req_op)
         2'b00:   op_res = req_a & req_b;
         2'b01:   op_res = req_a | req_b;
         2'b10:   op_res = req_a ^ req_b;
         default: op_res = ~(req_a | req_b);
      endcase
   end

   always_comb begin
      cur_byte = 8'(result >> {idx, 3'b000});
      byte_pop = '0;
      for (int i = 0; i < 8; i++) begin
         byte_pop = byte_pop + 4'(cur_byte[i]);
      end
   end

   // ready is registered so it stays low through reset and rises one edge after release
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         ready_q <= 1'b0;
         result  <= '0;
         acc     <= '0;
         idx     <= '0;
      end else begin
         case (state)
            IDLE: begin
               ready_q <= 1'b1;
               if (req_valid && ready_q) begin
                  result  <= op_res;
                  acc     <= '0;
                  idx     <= '0;
                  ready_q <= 1'b0;
                  state   <= COUNT;
               end
            end
            COUNT: begin
               acc <= acc + POPW'(byte_pop);
               idx <= idx + 1'b1;
               if (idx == IDXW'(NBYTES - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b0;
               result  <= '0;
               acc     <= '0;
               idx     <= '0;
            end
         endcase
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = (state == DONE);
   assign rsp_data  = rsp_valid ? result : '0;
   assign rsp_pop   = rsp_valid ? acc : '0;
   assign rsp_zero  = rsp_valid && (result == '0);

endmodule

// File: tb/tb_logic_unit_mc.sv
// Bench for logic_unit_mc: directed cases with literal expectations plus a randomized soak
// checked every cycle against a transaction-level reference model.
module tb_logic_unit_mc;

   localparam int WIDTH = 32;
   localparam int POPW  = 6;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [1:0]       req_op = 2'b00;
   logic [WIDTH-1:0] req_a = '0;
   logic [WIDTH-1:0] req_b = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_data;
   logic [POPW-1:0]  rsp_pop;
   logic             rsp_zero;

   always #5 clk = ~clk;

   logic_unit_mc #(.WIDTH(WIDTH), .POPW(POPW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_pop(rsp_pop), .rsp_zero(rsp_zero)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // Transaction model: accept when ready, answer WIDTH/8 edges later, hold until taken.
   bit               m_ready = 1'b0;
   bit               m_valid = 1'b0;
   bit               m_busy = 1'b0;
   bit               m_rst = 1'b1;
   logic [WIDTH-1:0] m_data = '0;
   int               m_pop = 0;
   int               m_wait = 0;
   int               m_acc = 0;
   int               m_done = 0;
   int               d_acc = 0;
   int               d_done = 0;

   always @(posedge clk) begin
      if (rst_n && req_valid && req_ready) d_acc++;
      if (rst_n && rsp_valid && rsp_ready) d_done++;
      m_rst = !rst_n;
      if (!rst_n) begin
         m_ready = 1'b0;
         m_valid = 1'b0;
         m_busy  = 1'b0;
         m_data  = '0;
         m_pop   = 0;
      end else if (m_valid) begin
         if (rsp_ready) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_ready = 1'b1;
            m_done++;
         end
      end else if (m_busy) begin
         m_wait--;
         if (m_wait == 0) m_valid = 1'b1;
      end else if (m_ready && req_valid) begin
         m_data  = ref_op(req_op, req_a, req_b);
         m_pop   = $countones(m_data);
         m_wait  = WIDTH / 8;
         m_busy  = 1'b1;
         m_ready = 1'b0;
         m_acc++;
      end else begin
         m_ready = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("rsp_valid", rsp_valid, m_valid);
         chk("req_ready", req_ready, m_ready);
         if (m_valid) begin
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_pop", rsp_pop, m_pop);
            chk("rsp_zero", rsp_zero, m_data == '0);
         end else if (m_rst) begin
            chk("rst_data", rsp_data, 0);
            chk("rst_pop", rsp_pop, 0);
            chk("rst_zero", rsp_zero, 0);
         end
      end
   end

   task automatic do_txn(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] edata, input int epop, input int stall);
      int w;
      int lat;
      w = 0;
      while (!req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", req_ready, 1);
      rsp_ready = (stall == 0);
      req_op = op;
      req_a = a;
      req_b = b;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      req_a = $urandom;
      req_b = $urandom;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         chk("busy_ready", req_ready, 0);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, WIDTH / 8);
      chk("lit_data", rsp_data, edata);
      chk("lit_pop", rsp_pop, epop);
      chk("lit_zero", rsp_zero, edata == '0);
      for (int i = 0; i < stall; i++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_op = 2'($urandom);
         req_a = $urandom;
         req_b = $urandom;
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data", rsp_data, edata);
         chk("hold_pop", rsp_pop, epop);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_hs_valid", rsp_valid, 0);
      chk("post_hs_ready", req_ready, 1);
   endtask

   initial begin
      int start_acc;
      int cyc;
      logic [WIDTH-1:0] ra;

      @(negedge clk);
      chk_on = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_ready", req_ready, 0);
      chk("reset_valid", rsp_valid, 0);
      chk("reset_data", rsp_data, 0);
      chk("reset_pop", rsp_pop, 0);
      chk("reset_zero", rsp_zero, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_ready", req_ready, 1);

      do_txn(2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 8, 0);
      do_txn(2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32, 0);
      do_txn(2'b10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 0, 0);
      do_txn(2'b01, 32'h80000001, 32'h00000000, 32'h80000001, 2, 10);

      // abort a transaction while byte 2 is being counted
      req_op = 2'b01;
      req_a = 32'h12345678;
      req_b = 32'h0;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_valid", rsp_valid, 0);
      chk("abort_ready", req_ready, 0);
      chk("abort_data", rsp_data, 0);
      chk("abort_pop", rsp_pop, 0);
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", rsp_valid, 0);
      end
      rsp_ready = 1'b0;
      do_txn(2'b00, 32'hFFFFFFFF, 32'h00FF00FF, 32'h00FF00FF, 16, 0);

      start_acc = d_acc;
      cyc = 0;
      while (d_acc < start_acc + 1000 && cyc < 40000) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_op = 2'($urandom);
         ra = $urandom;
         req_a = ra;
         case ($urandom_range(0, 3))
            0: req_b = ra;
            1: req_b = '0;
            2: req_b = '1;
            default: req_b = $urandom;
         endcase
         rsp_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (10) @(negedge clk);
      rsp_ready = 1'b0;
      chk("soak_reached", d_acc >= start_acc + 1000, 1);
      chk("acc_count", d_acc, m_acc);
      chk("rsp_count", d_done, m_done);
      chk("one_rsp_per_req", d_done, d_acc - 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
